// File: rtl/cpu_pkg.sv
// Shared writeback request type, special register numbers and age helper
// for the register-file write path.
package cpu_pkg;
  localparam int unsigned PW      = 3;
  localparam int unsigned DW      = 8;
  localparam int unsigned REG_PAR = 6;
  localparam int unsigned REG_OUT = 7;
  localparam int unsigned SEQ_MAX = 5;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  // True when tag a was issued before tag b; compares modulo 2**w.
  function automatic logic age_older(input logic [SEQ_MAX-1:0] a,
                                     input logic [SEQ_MAX-1:0] b,
                                     input int unsigned        w);
    logic [SEQ_MAX-1:0] diff;
    diff = (a - b) >> (w - 1);
    return diff[0];
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small writeback queue: DEPTH entries of {wb_req_t, seq}, oldest-first,
// with per-slot occupancy so queued destinations can be reported as a mask.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEQW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic [SEQW-1:0]  push_seq,
  output logic             ready,
  input  logic             pop,
  output logic             valid,
  output wb_req_t          head_req,
  output logic [SEQW-1:0]  head_seq,
  output logic [2**PW-1:0] mask
);
  localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  wb_req_t          req_q [DEPTH];
  logic [SEQW-1:0]  seq_q [DEPTH];
  logic [DEPTH-1:0] occ;
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW-1:0]  rd_ptr;
  logic [CNTW-1:0]  count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTRW-1:0] bump(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign ready    = (count != CNTW'(DEPTH));
  assign valid    = (count != '0);
  assign do_push  = push && ready;
  assign do_pop   = pop && valid;
  assign head_req = req_q[rd_ptr];
  assign head_seq = seq_q[rd_ptr];

  // Pointers and occupancy; payload storage is flushed logically via occ/count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr      <= bump(wr_ptr);
        occ[wr_ptr] <= 1'b1;
      end
      if (do_pop) begin
        rd_ptr      <= bump(rd_ptr);
        occ[rd_ptr] <= 1'b0;
      end
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      req_q[wr_ptr] <= push_req;
      seq_q[wr_ptr] <= push_seq;
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (occ[i]) mask[req_q[i].addr] = 1'b1;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and load-return writebacks onto the single reg_file write port,
// draining oldest-first by arrival tag and exporting a pending-write mask.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned pw    = PW,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [pw-1:0]    a_addr,
  input  logic [7:0]       a_data,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [pw-1:0]    m_addr,
  input  logic [7:0]       m_data,
  output logic             wr_en,
  output logic [pw-1:0]    wr_addr,
  output logic [7:0]       dat_out,
  output logic [2**pw-1:0] pend_mask,
  output logic             out_wr,
  output logic             par_drop
);
  localparam int unsigned SEQW = $clog2(2 * DEPTH) + 2;

  logic [SEQW-1:0]  seq;
  logic [SEQW-1:0]  a_seq;
  logic [SEQW-1:0]  a_hseq;
  logic [SEQW-1:0]  m_hseq;
  wb_req_t          a_req;
  wb_req_t          m_req;
  wb_req_t          a_head;
  wb_req_t          m_head;
  wb_req_t          g_req;
  logic             a_acc;
  logic             m_acc;
  logic             a_push;
  logic             m_push;
  logic             a_hv;
  logic             m_hv;
  logic             gnt_a;
  logic             gnt_m;
  logic [2**pw-1:0] a_mask;
  logic [2**pw-1:0] m_mask;
  logic [2**pw-1:0] wr_mask;

  assign a_req  = '{addr: a_addr, data: a_data};
  assign m_req  = '{addr: m_addr, data: m_data};
  assign a_acc  = a_valid && a_ready;
  assign m_acc  = m_valid && m_ready;
  assign a_push = a_acc && (a_addr != pw'(REG_PAR));
  assign m_push = m_acc && (m_addr != pw'(REG_PAR));
  // Same-cycle arrivals: the load is treated as older.
  assign a_seq  = m_push ? seq + SEQW'(1) : seq;

  wb_fifo #(.DEPTH(DEPTH), .SEQW(SEQW)) u_fifo_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (a_push),
    .push_req (a_req),
    .push_seq (a_seq),
    .ready    (a_ready),
    .pop      (gnt_a),
    .valid    (a_hv),
    .head_req (a_head),
    .head_seq (a_hseq),
    .mask     (a_mask)
  );

  wb_fifo #(.DEPTH(DEPTH), .SEQW(SEQW)) u_fifo_m (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (m_push),
    .push_req (m_req),
    .push_seq (seq),
    .ready    (m_ready),
    .pop      (gnt_m),
    .valid    (m_hv),
    .head_req (m_head),
    .head_seq (m_hseq),
    .mask     (m_mask)
  );

  // Oldest-first grant between the two queue heads.
  always_comb begin
    gnt_a = 1'b0;
    gnt_m = 1'b0;
    if (a_hv && m_hv) begin
      if (age_older(SEQ_MAX'(a_hseq), SEQ_MAX'(m_hseq), SEQW)) gnt_a = 1'b1;
      else                                                      gnt_m = 1'b1;
    end else begin
      gnt_a = a_hv;
      gnt_m = m_hv;
    end
  end

  assign g_req = gnt_a ? a_head : m_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      dat_out  <= '0;
      out_wr   <= 1'b0;
      par_drop <= 1'b0;
    end else begin
      seq      <= seq + SEQW'(a_push) + SEQW'(m_push);
      wr_en    <= gnt_a || gnt_m;
      out_wr   <= (gnt_a || gnt_m) && (g_req.addr == pw'(REG_OUT));
      par_drop <= (a_acc && (a_addr == pw'(REG_PAR))) ||
                  (m_acc && (m_addr == pw'(REG_PAR)));
      if (gnt_a || gnt_m) begin
        wr_addr <= g_req.addr;
        dat_out <= g_req.data;
      end
    end
  end

  always_comb begin
    wr_mask = '0;
    if (wr_en) wr_mask[wr_addr] = 1'b1;
  end

  assign pend_mask = a_mask | m_mask | wr_mask;
endmodule
